cpu_mulx_seq: RTL and testbench

- Iterative 32x32 multiply sequencer for the Nios II CPU execute path; feeds A-stage multiply results to the writeback mux.
- Handles MUL (low 32 bits) and the MULXUU/MULXSU/MULXSS high-word variants.
- Uses one registered 16x16 unsigned multiplier cell four times per operation, with a single-cycle sign-correction step.
- Valid/ready handshake on both sides; the CPU stalls on in_ready/out_valid.

---
 rtl/cpu_mulx_pkg.sv | 40 ++++
 rtl/cpu_mulx_seq_mul16.sv | 20 ++
 rtl/cpu_mulx_seq.sv | 117 +++++++++++
 tb/tb_cpu_mulx_seq.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mulx_pkg.sv
// Shared types and constants for the iterative multiply sequencer.
// Used by the sequencer top and its registered 16x16 multiplier cell.
package cpu_mulx_pkg;

    localparam int DATA_W       = 32;
    localparam int HALF_W       = 16;
    localparam int MULX_LATENCY = 7;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULXUU = 2'b01,
        OP_MULXSU = 2'b10,
        OP_MULXSS = 2'b11
    } mul_op_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_FIX,
        S_DONE
    } seq_state_t;

    // High word of the signed product, derived from the unsigned one mod 2^32
    function automatic logic [31:0] fix_high(
        input logic [31:0] hi,
        input mul_op_t     op,
        input logic [31:0] a,
        input logic [31:0] b
    );
        logic [31:0] r;
        r = hi;
        if ((op == OP_MULXSU || op == OP_MULXSS) && a[31])
            r = r - b;
        if (op == OP_MULXSS && b[31])
            r = r - a;
        return r;
    endfunction

endpackage

// File: rtl/cpu_mulx_seq_mul16.sv
// 16x16 unsigned multiplier with a registered 32-bit product.
// Synchronous active-high clear; no enable so it maps onto a DSP block.
module cpu_mul16_reg
    import cpu_mulx_pkg::*;
(
    input  logic              clk,
    input  logic              clear,
    input  logic [HALF_W-1:0] a,
    input  logic [HALF_W-1:0] b,
    output logic [DATA_W-1:0] prod
);

    always_ff @(posedge clk) begin
        if (clear)
            prod <= '0;
        else
            prod <= {16'b0, a} * {16'b0, b};
    end

endmodule

// File: rtl/cpu_mulx_seq.sv
// Iterative 32x32 multiply sequencer (MUL / MULXUU / MULXSU / MULXSS).
// Four passes through one registered 16x16 cell, then one sign-fix cycle.
module cpu_mulx_seq
    import cpu_mulx_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [DATA_W-1:0] in_src1,
    input  logic [DATA_W-1:0] in_src2,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result
);

    seq_state_t        state;
    mul_op_t           op;
    logic [31:0]       src1;
    logic [31:0]       src2;
    logic [63:0]       acc;
    logic [1:0]        cnt;
    logic [HALF_W-1:0] cell_a;
    logic [HALF_W-1:0] cell_b;
    logic [31:0]       prod;
    logic [63:0]       pp_sh;

    // cnt 0..3 issues (lo,lo) (hi,lo) (lo,hi) (hi,hi)
    assign cell_a = cnt[0] ? src1[31:16] : src1[15:0];
    assign cell_b = cnt[1] ? src2[31:16] : src2[15:0];

    cpu_mul16_reg u_cell (
        .clk   (clk),
        .clear (reset | flush),
        .a     (cell_a),
        .b     (cell_b),
        .prod  (prod)
    );

    // Product issued at cnt-1 lands now; DRAIN takes the (hi,hi) term
    always_comb begin
        pp_sh = '0;
        if (state == S_DRAIN) begin
            pp_sh = {prod, 32'b0};
        end else if (state == S_ISSUE) begin
            case (cnt)
                2'd1:    pp_sh = {32'b0, prod};
                2'd2,
                2'd3:    pp_sh = {16'b0, prod, 16'b0};
                default: pp_sh = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_result <= '0;
            acc        <= '0;
            cnt        <= '0;
            op         <= OP_MUL;
            src1       <= '0;
            src2       <= '0;
        end else if (flush) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        src1     <= in_src1;
                        src2     <= in_src2;
                        op       <= mul_op_t'(in_op);
                        acc      <= '0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    acc <= acc + pp_sh;
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'd3)
                        state <= S_DRAIN;
                end
                S_DRAIN: begin
                    acc   <= acc + pp_sh;
                    state <= S_FIX;
                end
                S_FIX: begin
                    out_result <= (op == OP_MUL) ? acc[31:0]
                                : fix_high(acc[63:32], op, src1, src2);
                    out_valid  <= 1'b1;
                    state      <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_mulx_seq.sv
// Directed and randomized checks for the multiply sequencer.
// Expected values come from hand-computed constants and a 64-bit model.
module tb_cpu_mulx_seq;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_src1;
    logic [31:0] in_src2;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;

    int n_assert;
    int n_fail;

    cpu_mulx_seq dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_src1    (in_src1),
        .in_src2    (in_src2),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_mul(input logic [1:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [63:0] x;
        logic signed [63:0] y;
        logic signed [63:0] p;
        x = op[1] ? {{32{a[31]}}, a} : {32'b0, a};
        y = (op == 2'b11) ? {{32{b[31]}}, b} : {32'b0, b};
        p = x * y;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    // Issue one op with out_ready high; returns latency and result
    task automatic do_op(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, output int lat,
                         output logic [31:0] res);
        int g;
        g = 0;
        @(negedge clk);
        while (!in_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        in_valid  = 1'b1;
        in_op     = op;
        in_src1   = a;
        in_src2   = b;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_src1  = $urandom;
        in_src2  = $urandom;
        in_op    = 2'($urandom);
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        res = out_result;
        @(posedge clk);
    endtask

    logic [31:0] res;
    logic [31:0] held;
    logic [31:0] exp;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [1:0]  rop;
    int          lat;
    int          g;
    int          k;
    int          fl;
    int          first;
    bit          done;
    bit          took;
    bit          seen;

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_op     = 2'b00;
        in_src1   = '0;
        in_src2   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_result", out_result, 32'h0);
        reset = 1'b0;

        do_op(2'b00, 32'h00010003, 32'h00020005, lat, res);
        chk("mul_res", res, 32'h000B000F);
        chk("mul_latency", 32'(lat), 32'd7);
        do_op(2'b01, 32'h00010003, 32'h00020005, lat, res);
        chk("mulxuu_small", res, 32'h00000002);
        do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, res);
        chk("mulxuu_ones", res, 32'hFFFFFFFE);
        do_op(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, res);
        chk("mulxss_ones", res, 32'h00000000);
        do_op(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, res);
        chk("mulxsu_ones", res, 32'hFFFFFFFF);
        do_op(2'b11, 32'h80000000, 32'h80000000, lat, res);
        chk("mulxss_min", res, 32'h40000000);
        do_op(2'b10, 32'h80000000, 32'h00000003, lat, res);
        chk("mulxsu_min3", res, 32'hFFFFFFFE);

        // Backpressure in DONE
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_op     = 2'b01;
        in_src1   = 32'h12345678;
        in_src2   = 32'h9ABCDEF0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        g = 0;
        while (!out_valid && g < 20) begin
            @(negedge clk);
            g++;
        end
        held = out_result;
        chk("bp_res", held, 32'h0B00EA4E);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_stable", out_result, 32'h0B00EA4E);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_handoff_valid", 32'(out_valid), 32'd0);
        chk("bp_handoff_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_op    = 2'b00;
        in_src1  = 32'd3;
        in_src2  = 32'd4;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_next_accept", 32'(in_ready), 32'd0);
        g = 0;
        while (!out_valid && g < 20) begin
            @(negedge clk);
            g++;
        end
        chk("bp_next_res", out_result, 32'h0000000C);
        out_ready = 1'b1;
        @(posedge clk);

        // Flush and reset at cnt=2
        for (int m = 0; m < 2; m++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_op    = 2'b01;
            in_src1  = 32'hDEADBEEF;
            in_src2  = 32'hCAFEF00D;
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            @(negedge clk);
            @(negedge clk);
            if (m == 0) flush = 1'b1;
            else        reset = 1'b1;
            @(posedge clk);
            @(negedge clk);
            flush = 1'b0;
            reset = 1'b0;
            chk(m == 0 ? "fl_in_ready" : "rs_in_ready", 32'(in_ready), 32'd1);
            seen = 1'b0;
            for (int i = 0; i < 8; i++) begin
                if (out_valid) seen = 1'b1;
                @(negedge clk);
            end
            chk(m == 0 ? "fl_no_valid" : "rs_no_valid", 32'(seen), 32'd0);
            if (m == 1)
                chk("rs_out_result", out_result, 32'h0);
            do_op(2'b00, 32'd3, 32'd4, lat, res);
            chk(m == 0 ? "fl_recover" : "rs_recover", res, 32'h0000000C);
        end

        // Random ops with stalls and flush injection
        for (int i = 0; i < 600; i++) begin
            rop = 2'($urandom);
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 5))
                0: ra = 32'h80000000;
                1: rb = 32'hFFFFFFFF;
                2: ra = 32'h0;
                default: ;
            endcase
            exp = ref_mul(rop, ra, rb);
            @(negedge clk);
            g = 0;
            while (!in_ready && g < 20) begin
                @(negedge clk);
                g++;
            end
            in_valid = 1'b1;
            in_op    = rop;
            in_src1  = ra;
            in_src2  = rb;
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            in_src1  = $urandom;
            in_src2  = $urandom;
            fl = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            done  = 1'b0;
            first = 0;
            k     = 1;
            while (!done && k < 60) begin
                out_ready = 1'($urandom_range(0, 1));
                if (k == fl) begin
                    flush = 1'b1;
                    @(posedge clk);
                    @(negedge clk);
                    flush = 1'b0;
                    chk("rnd_flush", {30'b0, out_valid, in_ready}, 32'd1);
                    done = 1'b1;
                end else begin
                    if (out_valid) begin
                        chk("rnd_res", out_result, exp);
                        if (first == 0) begin
                            first = k;
                            chk("rnd_latency", 32'(k), 32'd7);
                        end
                    end
                    took = out_valid && out_ready;
                    @(posedge clk);
                    @(negedge clk);
                    k++;
                    if (took) begin
                        chk("rnd_handoff", 32'(out_valid), 32'd0);
                        done = 1'b1;
                    end
                end
            end
            if (!done)
                chk("rnd_timeout", 32'(done), 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
